// File: rtl/carry_skip_adder_pkg.sv
// Package: carry_skip_pkg
// Purpose : shared defaults and helpers for the carry-skip adder slice.
//   CSA_OPERAND_SIZE_DEF : default operand width (bits)
//   CSA_BLOCK_SIZE_DEF   : default skip-block width (bits)
//   csa_num_blocks()     : number of skip blocks for a given operand/block size
package carry_skip_pkg;

  localparam int CSA_OPERAND_SIZE_DEF = 16;
  localparam int CSA_BLOCK_SIZE_DEF   = 4;

  // A zero block size is rejected at elaboration by the top level; returning 1
  // here keeps the block count well defined until that error is raised.
  function automatic int csa_num_blocks(input int op, input int blk);
    return (blk > 0) ? (op / blk) : 1;
  endfunction

endpackage

// File: rtl/carry_skip_adder_if.sv
// Interface: carry_skip_adder_if
// Purpose  : operand/result bundle of the carry-skip adder.
//   A, B   : unsigned addends (OPERAND_SIZE bits)
//   Cin    : carry into bit 0
//   Sout   : registered sum
//   Cout   : registered carry out of the MSB block
// Modports : master drives operands and reads results; slave is the adder.
interface carry_skip_adder_if
  import carry_skip_pkg::*;
#(
  parameter int OPERAND_SIZE = CSA_OPERAND_SIZE_DEF
);

  logic [OPERAND_SIZE-1:0] A;
  logic [OPERAND_SIZE-1:0] B;
  logic                    Cin;
  logic [OPERAND_SIZE-1:0] Sout;
  logic                    Cout;

  modport master (output A, B, Cin, input Sout, Cout);
  modport slave  (input A, B, Cin, output Sout, Cout);

endinterface

// File: rtl/carry_skip_adder_block.sv
// Module : carry_skip_block
// Purpose: one ripple-carry block with a skip mux on its carry-out.
//   a, b : block slice of the addends (BLOCK_SIZE bits)
//   cin  : carry into the block (C_k)
//   sum  : block sum bits
//   cout : carry out of the block (C_k+1), bypassed to cin when prop is set
//   prop : block propagate, AND of all bit propagates
module carry_skip_block #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic [BLOCK_SIZE-1:0] a,
  input  logic [BLOCK_SIZE-1:0] b,
  input  logic                  cin,
  output logic [BLOCK_SIZE-1:0] sum,
  output logic                  cout,
  output logic                  prop
);

  logic [BLOCK_SIZE-1:0] p;
  logic [BLOCK_SIZE-1:0] g;
  logic                  ripple_cout;

  assign p = a ^ b;
  assign g = a & b;

  // Ripple carry held in a procedural variable so the chain is a single
  // ordered evaluation rather than a self-referencing vector.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sum[i] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
    end
    ripple_cout = c;
  end

  assign prop = &p;
  assign cout = prop ? cin : ripple_cout;

endmodule

// File: rtl/carry_skip_adder.sv
// Module : carry_skip_adder
// Purpose: parameterised carry-skip adder, {Cout, Sout} = A + B + Cin,
//          with registered outputs (1-cycle latency).
// Ports  : clk   - clock, rising edge
//          rst_n - asynchronous active-low reset, clears all registers
//          bus   - carry_skip_adder_if.slave (A, B, Cin in; Sout, Cout out)
// Macro  : CARRY_SKIP_INPUT_REG_EN - when defined, A/B/Cin are registered
//          ahead of the adder (latency 2 cycles).
module carry_skip_adder
  import carry_skip_pkg::*;
#(
  parameter int OPERAND_SIZE = CSA_OPERAND_SIZE_DEF,
  parameter int BLOCK_SIZE   = CSA_BLOCK_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  carry_skip_adder_if.slave   bus
);

  localparam int NB = csa_num_blocks(OPERAND_SIZE, BLOCK_SIZE);
  localparam bit PARAM_BAD = (OPERAND_SIZE < 1) || (BLOCK_SIZE < 1) ||
                             ((BLOCK_SIZE < 1) ? 1'b1 : ((OPERAND_SIZE % BLOCK_SIZE) != 0));

  if (PARAM_BAD) begin : g_param_err
    $error("carry_skip_adder: illegal OPERAND_SIZE=%0d / BLOCK_SIZE=%0d", OPERAND_SIZE, BLOCK_SIZE);
  end

  logic [OPERAND_SIZE-1:0] a_in;
  logic [OPERAND_SIZE-1:0] b_in;
  logic                    cin_in;

`ifdef CARRY_SKIP_INPUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_in   <= '0;
      b_in   <= '0;
      cin_in <= 1'b0;
    end else begin
      a_in   <= bus.A;
      b_in   <= bus.B;
      cin_in <= bus.Cin;
    end
  end
`else
  assign a_in   = bus.A;
  assign b_in   = bus.B;
  assign cin_in = bus.Cin;
`endif

  logic [OPERAND_SIZE-1:0] sum_c;
  logic                    cout_c;
  logic [NB-1:0]           prop_unused;

  // Each block takes its carry-in from the previous block's skip-muxed
  // carry-out; block 0 takes Cin.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic c_in;
    logic c_out;

    if (k == 0) begin : g_first
      assign c_in = cin_in;
    end else begin : g_next
      assign c_in = g_blk[k-1].c_out;
    end

    carry_skip_block #(
      .BLOCK_SIZE (BLOCK_SIZE)
    ) u_blk (
      .a    (a_in[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .b    (b_in[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .cin  (c_in),
      .sum  (sum_c[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .cout (c_out),
      .prop (prop_unused[k])
    );
  end

  assign cout_c = g_blk[NB-1].c_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Sout <= '0;
      bus.Cout <= 1'b0;
    end else begin
      bus.Sout <= sum_c;
      bus.Cout <= cout_c;
    end
  end

endmodule

// File: tb/tb_carry_skip_adder.sv
`timescale 1ns/1ps
module tb_carry_skip_adder;
  import carry_skip_pkg::*;

`ifdef CARRY_SKIP_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carry_skip_adder_if #(.OPERAND_SIZE(16)) bus0 ();
  carry_skip_adder_if #(.OPERAND_SIZE(16)) bus1 ();
  carry_skip_adder_if #(.OPERAND_SIZE(32)) bus2 ();
  carry_skip_adder_if #(.OPERAND_SIZE(8))  bus3 ();

  carry_skip_adder #(.OPERAND_SIZE(16), .BLOCK_SIZE(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  carry_skip_adder #(.OPERAND_SIZE(16), .BLOCK_SIZE(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  carry_skip_adder #(.OPERAND_SIZE(32), .BLOCK_SIZE(8))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  carry_skip_adder #(.OPERAND_SIZE(8),  .BLOCK_SIZE(1))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] obs0();
    return {16'h0, bus0.Cout, bus0.Sout};
  endfunction
  function automatic logic [32:0] obs1();
    return {16'h0, bus1.Cout, bus1.Sout};
  endfunction
  function automatic logic [32:0] obs2();
    return {bus2.Cout, bus2.Sout};
  endfunction
  function automatic logic [32:0] obs3();
    return {24'h0, bus3.Cout, bus3.Sout};
  endfunction

  // Behavioural reference: low w bits of both operands plus carry, w+1 bit result.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input int w);
    logic [32:0] m;
    m = (33'h1 << w) - 33'h1;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {32'h0, cin};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus0.A = a[15:0]; bus0.B = b[15:0]; bus0.Cin = cin;
    bus1.A = a[15:0]; bus1.B = b[15:0]; bus1.Cin = cin;
    bus2.A = a;       bus2.B = b;       bus2.Cin = cin;
    bus3.A = a[7:0];  bus3.B = b[7:0];  bus3.Cin = cin;
  endtask

  // Apply one vector, hold it for the pipeline latency, check the 16/4 adder.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [32:0] exp);
    drive({16'h0, a}, {16'h0, b}, cin);
    repeat (LAT) @(posedge clk);
    #1;
    check(tag, obs0(), exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d0"}, obs0(), 33'h0);
    check({tag, "_d1"}, obs1(), 33'h0);
    check({tag, "_d2"}, obs2(), 33'h0);
    check({tag, "_d3"}, obs3(), 33'h0);
  endtask

  localparam int NV = 6;
  logic [15:0] va [NV] = '{16'h0001, 16'hFFFF, 16'h0F0F, 16'h7FFF, 16'hABCD, 16'hFFFF};
  logic [15:0] vb [NV] = '{16'h0001, 16'h0001, 16'hF0F0, 16'h0001, 16'h1111, 16'hFFFF};
  logic        vc [NV] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
  logic [32:0] ve [NV] = '{33'h00002, 33'h10000, 33'h10000, 33'h08000, 33'h0BCDE, 33'h1FFFE};

  initial begin
    logic [31:0] ra, rb;
    logic        rc;

    // Reset held with all-ones operands: outputs must stay zero.
    rst_n = 1'b0;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    #2;
    check_all_zero("rst_hold");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold_clk");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("rst_release", obs0(), 33'h1FFFF);

    // Directed vectors on the 16/4 adder.
    step("skip_chain",   16'hFFFF, 16'h0000, 1'b1, 33'h10000);
    step("ripple_mix",   16'h1234, 16'h4321, 1'b0, 33'h05555);
    step("ripple_carry", 16'h00FF, 16'h0001, 1'b0, 33'h00100);
    step("overflow",     16'h8000, 16'h8000, 1'b0, 33'h10000);
    step("cin_only",     16'h0000, 16'h0000, 1'b1, 33'h00001);

    // Full-propagate boundaries on the other geometries.
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (LAT) @(posedge clk);
    #1;
    check("skip_16_16", obs1(), 33'h10000);
    check("skip_32_8",  obs2(), 33'h1_0000_0000);
    check("skip_8_1",   obs3(), 33'h00100);

    // Back-to-back: a new vector each cycle, result LAT cycles later.
    for (int i = 0; i < NV + LAT - 1; i++) begin
      if (i < NV) drive({16'h0, va[i]}, {16'h0, vb[i]}, vc[i]);
      @(posedge clk);
      #1;
      if (i - LAT + 1 >= 0) check($sformatf("b2b_%0d", i - LAT + 1), obs0(), ve[i - LAT + 1]);
    end

    // Reset mid-stream: in-flight result is discarded, outputs clear at once.
    step("pre_rst", 16'h1234, 16'h4321, 1'b0, 33'h05555);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("mid_rst_clk");
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0000_0001, 32'h0000_0002, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    check("post_rst", obs0(), 33'h00003);

    // Random vectors on all four geometries.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rc);
      repeat (LAT) @(posedge clk);
      #1;
      check("rnd_16_4",  obs0(), model(ra, rb, rc, 16));
      check("rnd_16_16", obs1(), model(ra, rb, rc, 16));
      check("rnd_32_8",  obs2(), model(ra, rb, rc, 32));
      check("rnd_8_1",   obs3(), model(ra, rb, rc, 8));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/carry_skip_adder.md
# carry_skip_adder

Parameterised carry-skip (carry-bypass) adder producing `{Cout, Sout} = A + B + Cin` with registered outputs. The operand is split into fixed-size ripple-carry blocks; each block's carry-out is bypassed by a skip multiplexer when every bit in the block propagates. It serves as a mid-latency arithmetic primitive in datapaths where ripple delay is too long and a full carry-lookahead adder is too large.

## Interface
- `OPERAND_SIZE`, default 16: operand and sum width in bits; must be ≥ 1.
- `BLOCK_SIZE`, default 4: bits per skip block; must be ≥ 1 and must divide `OPERAND_SIZE` exactly.
- `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `A`, input, `OPERAND_SIZE` bits: addend, unsigned.
- `B`, input, `OPERAND_SIZE` bits: addend, unsigned.
- `Cin`, input, 1 bit: carry into bit 0.
- `Sout`, output, `OPERAND_SIZE` bits: registered sum, low `OPERAND_SIZE` bits of `A + B + Cin`.
- `Cout`, output, 1 bit: registered carry out of the MSB block.

## Operation
- `NB = OPERAND_SIZE / BLOCK_SIZE` blocks. Block k covers bits `[k*BLOCK_SIZE +: BLOCK_SIZE]`.
- Per bit: `p = a ^ b`, `g = a & b`, `s = p ^ c_in_bit`. Carries ripple within a block.
- Block propagate `P_k` = AND of all p bits in block k.
- Block carry-out `C_{k+1} = P_k ? C_k : ripple_cout_k`, with `C_0 = Cin`. `Cout = C_NB`.
- Result is bit-exact with `A + B + Cin` computed at `OPERAND_SIZE+1` bits. Overflow wraps into `Cout` only; there is no saturation and no signed interpretation.
- Illegal parameters, meaning `OPERAND_SIZE % BLOCK_SIZE != 0` or a zero value, cause an elaboration-time `$error`.
- `BLOCK_SIZE == OPERAND_SIZE` degenerates to a single ripple block with one skip mux. This case is legal.

## Timing
- The combinational sum is captured in `Sout`/`Cout` on every rising `clk`. There is no handshake and no enable: a new operand set may be applied every cycle.
- Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- While `rst_n` = 0: `Sout` = 0 and `Cout` = 0 immediately, independent of `clk`.
- On deassertion, the first edge with `rst_n` = 1 captures the current inputs.
- Reset asserted mid-stream discards the in-flight result. There is no partial state.

## Configuration
- `CARRY_SKIP_INPUT_REG_EN` defined: `A`, `B` and `Cin` are additionally registered, with the same async reset to 0, before the adder. Latency becomes 2 cycles. Outputs still reset to 0.
- `CARRY_SKIP_INPUT_REG_EN` undefined: inputs feed the adder combinationally and latency is 1 cycle.

## Structure
- Package `carry_skip_pkg`:
  - default constants `CSA_OPERAND_SIZE_DEF = 16` and `CSA_BLOCK_SIZE_DEF = 4`;
  - function `csa_num_blocks(op, blk)` returning `op / blk`.
- Sub-module `carry_skip_block`:
  - parameter `BLOCK_SIZE`;
  - inputs `a`, `b`, `cin`; outputs `sum`, `cout` (the skip-muxed carry), `prop`.
  - Instantiated `NB` times via generate, chained through `C_k`.
- The top level holds only the block chain and the output (and optional input) registers.

## Test plan
- Reset: hold `rst_n`=0 with A=16'hFFFF, B=16'hFFFF, Cin=1 -> Sout=16'h0000, Cout=0. Then release; after 1 edge, Sout=16'hFFFF, Cout=1.
- Full skip chain: A=16'hFFFF, B=16'h0000, Cin=1 -> Sout=16'h0000, Cout=1. Every block takes the bypass path.
- Ripple and generate mix: A=16'h1234, B=16'h4321, Cin=0 -> Sout=16'h5555, Cout=0. Then A=16'h00FF, B=16'h0001, Cin=0 -> Sout=16'h0100, Cout=0.
- Overflow: A=16'h8000, B=16'h8000, Cin=0 -> Sout=16'h0000, Cout=1. Also A=0, B=0, Cin=1 -> Sout=16'h0001, Cout=0.
- Back-to-back and reset mid-stream: apply a new vector every cycle and check each result exactly 1 cycle later (2 with `CARRY_SKIP_INPUT_REG_EN`). Assert `rst_n` between edges -> outputs go to 0 at once.
- Random: 100 vectors of random A, B and Cin, compared against a behavioural `A + B + Cin` model. Repeat with `OPERAND_SIZE`/`BLOCK_SIZE` set to 16/4, 16/16, 32/8 and 8/1.
